rgb_to_hsl: RTL



---
 rtl/rgb_to_hsl_if.sv | 28 ++
 rtl/rgb_to_hsl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_hsl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgb_to_hsl_if : valid/ready colour-in / colour-out bundle for rgb_to_hsl   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface rgb_to_hsl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] H;
  logic [7:0] S;
  logic [7:0] L;

  modport master (
    output in_valid, R, G, B, out_ready,
    input  in_ready, out_valid, H, S, L
  );

  modport slave (
    input  in_valid, R, G, B, out_ready,
    output in_ready, out_valid, H, S, L
  );
endinterface
`default_nettype wire

// File: rtl/rgb_to_hsl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgb_to_hsl : sequential RGB->HSL converter, one shared restoring divider.  |
// | Optional: RGB_TO_HSL_FAST_GREY_EN skips the divide phases for grey input.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module rgb_to_hsl (
  input logic         clk,
  input logic         rst_n,
  rgb_to_hsl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_DIV_S = 3'd2,
    ST_DIV_H = 3'd3,
    ST_FINAL = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] c_LAST_ITER = 4'd15;
  localparam logic [1:0] c_SEL_R     = 2'd0;
  localparam logic [1:0] c_SEL_G     = 2'd1;
  localparam logic [1:0] c_SEL_B     = 2'd2;

  state_t      r_state;
  state_t      w_state_nx;

  logic [7:0]  r_r;
  logic [7:0]  r_g;
  logic [7:0]  r_b;

  logic [1:0]  r_sel;
  logic        r_h_neg;
  logic [7:0]  r_num_abs;
  logic [7:0]  r_delta;
  logic [7:0]  r_l;
  logic        r_grey;

  logic [15:0] r_dvd;
  logic [7:0]  r_rem;
  logic [7:0]  r_dvs;
  logic [3:0]  r_cnt;

  logic [7:0]  r_s_q;
  logic [10:0] r_h6;

  logic [7:0]  r_h;
  logic [7:0]  r_s;
  logic [7:0]  r_lo;
  logic        r_out_valid;

  logic [1:0]  w_sel;
  logic [7:0]  w_max;
  logic [7:0]  w_min;
  logic [7:0]  w_delta;
  logic [8:0]  w_sum;
  logic        w_grey;
  logic [7:0]  w_num_a;
  logic [7:0]  w_num_b;
  logic        w_h_neg;
  logic [7:0]  w_num_abs;
  logic [7:0]  w_s_dvs;
  logic [15:0] w_s_dvd;

  logic [8:0]  w_rem_sh;
  logic        w_ge;
  logic [7:0]  w_rem_nx;
  logic [15:0] w_dvd_nx;
  logic [8:0]  w_q;
  logic [10:0] w_h6;
  logic [7:0]  w_hue;
  logic        w_last;

  // Channel analysis on the latched colour; only consumed while in PREP.
  always_comb begin
    w_sel = c_SEL_B;
    w_max = r_b;
    if (r_r >= r_g && r_r >= r_b) begin
      w_sel = c_SEL_R;
      w_max = r_r;
    end else if (r_g >= r_b) begin
      w_sel = c_SEL_G;
      w_max = r_g;
    end

    w_min = r_r;
    if (r_g < w_min) w_min = r_g;
    if (r_b < w_min) w_min = r_b;

    w_num_a = r_r;
    w_num_b = r_g;
    case (w_sel)
      c_SEL_R: begin
        w_num_a = r_g;
        w_num_b = r_b;
      end
      c_SEL_G: begin
        w_num_a = r_b;
        w_num_b = r_r;
      end
      default: begin
        w_num_a = r_r;
        w_num_b = r_g;
      end
    endcase
  end

  assign w_delta   = w_max - w_min;
  assign w_sum     = {1'b0, w_max} + {1'b0, w_min};
  assign w_grey    = (w_delta == 8'd0);
  assign w_h_neg   = (w_num_a < w_num_b);
  assign w_num_abs = w_h_neg ? (w_num_b - w_num_a) : (w_num_a - w_num_b);

  // Lightness above mid-scale divides by the distance from full white instead.
  assign w_s_dvs = w_sum[8] ? 8'(9'd510 - w_sum) : w_sum[7:0];
  assign w_s_dvd = {w_delta, 8'h00} - {8'h00, w_delta};

  // One restoring-division step; the quotient shifts in behind the dividend.
  assign w_rem_sh = {r_rem, r_dvd[15]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nx = w_ge ? 8'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[7:0];
  assign w_dvd_nx = {r_dvd[14:0], w_ge};
  assign w_last   = (r_cnt == c_LAST_ITER);

  assign w_q = w_dvd_nx[8:0];

  // Hue in sixths of a circle, 256 per sector, 1536 per turn.
  always_comb begin
    w_h6 = {2'b00, w_q};
    case (r_sel)
      c_SEL_R: w_h6 = r_h_neg ? (11'd1536 - {2'b00, w_q}) : {2'b00, w_q};
      c_SEL_G: w_h6 = r_h_neg ? (11'd512 - {2'b00, w_q}) : (11'd512 + {2'b00, w_q});
      default: w_h6 = r_h_neg ? (11'd1024 - {2'b00, w_q}) : (11'd1024 + {2'b00, w_q});
    endcase
  end

  // 171/1024 approximates 256/1536 to rescale sixths to a byte-wide circle.
  assign w_hue = 8'((r_h6 * 19'd171) >> 10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (bus.in_valid) w_state_nx = ST_PREP;
      ST_PREP: begin
`ifdef RGB_TO_HSL_FAST_GREY_EN
        w_state_nx = w_grey ? ST_FINAL : ST_DIV_S;
`else
        w_state_nx = ST_DIV_S;
`endif
      end
      ST_DIV_S: if (w_last) w_state_nx = ST_DIV_H;
      ST_DIV_H: if (w_last) w_state_nx = ST_FINAL;
      ST_FINAL: w_state_nx = ST_DONE;
      ST_DONE:  if (bus.out_ready) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r         <= 8'd0;
      r_g         <= 8'd0;
      r_b         <= 8'd0;
      r_sel       <= c_SEL_R;
      r_h_neg     <= 1'b0;
      r_num_abs   <= 8'd0;
      r_delta     <= 8'd0;
      r_l         <= 8'd0;
      r_grey      <= 1'b0;
      r_dvd       <= 16'd0;
      r_rem       <= 8'd0;
      r_dvs       <= 8'd0;
      r_cnt       <= 4'd0;
      r_s_q       <= 8'd0;
      r_h6        <= 11'd0;
      r_h         <= 8'd0;
      r_s         <= 8'd0;
      r_lo        <= 8'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_r <= bus.R;
            r_g <= bus.G;
            r_b <= bus.B;
          end
        end
        ST_PREP: begin
          r_sel     <= w_sel;
          r_h_neg   <= w_h_neg;
          r_num_abs <= w_num_abs;
          r_delta   <= w_delta;
          r_l       <= w_sum[8:1];
          r_grey    <= w_grey;
          r_dvd     <= w_s_dvd;
          r_dvs     <= w_s_dvs;
          r_rem     <= 8'd0;
          r_cnt     <= 4'd0;
          r_s_q     <= 8'd0;
          r_h6      <= 11'd0;
        end
        ST_DIV_S: begin
          r_cnt <= r_cnt + 4'd1;
          // Grey inputs keep the divider frozen and the zeroed results.
          if (!r_grey) begin
            if (w_last) begin
              r_s_q <= w_dvd_nx[7:0];
              r_dvd <= {r_num_abs, 8'h00};
              r_dvs <= r_delta;
              r_rem <= 8'd0;
            end else begin
              r_dvd <= w_dvd_nx;
              r_rem <= w_rem_nx;
            end
          end
        end
        ST_DIV_H: begin
          r_cnt <= r_cnt + 4'd1;
          if (!r_grey) begin
            if (w_last) begin
              r_h6 <= w_h6;
            end else begin
              r_dvd <= w_dvd_nx;
              r_rem <= w_rem_nx;
            end
          end
        end
        ST_FINAL: begin
          r_h         <= w_hue;
          r_s         <= r_s_q;
          r_lo        <= r_l;
          r_out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (bus.out_ready) r_out_valid <= 1'b0;
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.H         = r_h;
  assign bus.S         = r_s;
  assign bus.L         = r_lo;

endmodule
`default_nettype wire
